// File: rtl/fir_pkg.sv
// Shared constants and state encoding for the FIR host-side feeder.
// Frame pacing and coefficient count match the W4823 FIR block.
// Widths: FP16 samples/results, 17-bit coefficients, 6-bit coefficient address.
package fir_pkg;
  localparam int FRAME_CYCLES = 258;  // 1+63+6+64+1+123 fast cycles per FIR frame
  localparam int NCOEF        = 64;
  localparam int FP16_W       = 16;
  localparam int COEF_W       = 17;
  localparam int SLOT_W       = $clog2(FRAME_CYCLES);
  localparam int CADDR_W      = $clog2(NCOEF);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLOAD = 1'b1
  } state_t;
endpackage

// File: rtl/fir_result_fifo.sv
// Synchronous FIFO holding FIR results until downstream consumes them.
// Latency: empty deasserts the cycle after the first push; head is the oldest entry.
// Backpressure: a push while full is taken only together with a pop; otherwise ignored.
// Ports: clk/rst_n (sync, active-low); push+push_data write; pop reads; full/empty/head status.
module fir_result_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             wr_en;
  logic             rd_en;

  assign empty = (count == '0);
  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign rd_en = pop & ~empty;
  // A pop frees the head slot in the same cycle, so a full FIFO can still take a push.
  assign wr_en = push & (~full | rd_en);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/fir_feeder.sv
// Host-side driver for the W4823 FIR: coefficient loader, paced sample issuer, result FIFO.
// Latency: samples and coefficients reach the FIR one cycle after accept; results show on m_* one cycle after capture.
// Backpressure: s_ready paces one sample per FIR frame; cfg_cready only in CLOAD; results dropped (ovf_err) when FIFO full and not popped.
// Ports: clk2/rst_n (sync, active-low); cfg_* coefficient load; s_* sample stream in;
//        fir_* to/from the FIR block; m_* result stream out; ovf_err sticky drop flag.
module fir_feeder
  import fir_pkg::*;
#(
  parameter int OUT_DEPTH = 4
) (
  input  logic               clk2,
  input  logic               rst_n,
  input  logic               cfg_start,
  input  logic [COEF_W-1:0]  cfg_cdata,
  input  logic               cfg_cvalid,
  output logic               cfg_cready,
  output logic               cfg_busy,
  input  logic [FP16_W-1:0]  s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [FP16_W-1:0]  fir_din,
  output logic               fir_valid_in,
  output logic [COEF_W-1:0]  fir_cin,
  output logic [CADDR_W-1:0] fir_caddr,
  output logic               fir_cload,
  input  logic [FP16_W-1:0]  fir_dout,
  input  logic               fir_valid,
  output logic [FP16_W-1:0]  m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               ovf_err
);
  state_t             state;
  state_t             state_nxt;
  logic [SLOT_W-1:0]  slot_cnt;
  logic [CADDR_W-1:0] coef_idx;
  logic               s_acc;
  logic               c_acc;
  logic               last_coef;
  logic               slot_free;
  logic               res_pop;
  logic               res_full;
  logic               res_empty;
  logic               res_drop;

  assign slot_free = (slot_cnt == '0);
  assign s_acc     = s_ready & s_valid;
  assign c_acc     = cfg_cready & cfg_cvalid;
  assign last_coef = (coef_idx == CADDR_W'(NCOEF - 1));

  // State register
  always_ff @(posedge clk2) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state: a load may only start between frames; cfg_start is a level, so it just waits.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cfg_start && slot_free) state_nxt = ST_CLOAD;
      ST_CLOAD: if (c_acc && last_coef)     state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: cfg_start wins over a pending sample, and nothing is accepted while in reset.
  always_comb begin
    cfg_busy   = (state == ST_CLOAD);
    cfg_cready = (state == ST_CLOAD);
    s_ready    = rst_n && (state == ST_IDLE) && slot_free && !cfg_start;
  end

  // Datapath toward the FIR and frame pacing
  always_ff @(posedge clk2) begin
    if (!rst_n) begin
      slot_cnt     <= '0;
      coef_idx     <= '0;
      fir_din      <= '0;
      fir_valid_in <= 1'b0;
      fir_cin      <= '0;
      fir_caddr    <= '0;
      fir_cload    <= 1'b0;
      ovf_err      <= 1'b0;
    end else begin
      fir_valid_in <= s_acc;
      fir_cload    <= c_acc;

      if (s_acc) begin
        fir_din  <= s_data;
        slot_cnt <= SLOT_W'(FRAME_CYCLES - 1);
      end else if (!slot_free) begin
        slot_cnt <= slot_cnt - SLOT_W'(1);
      end

      // Every load starts at address 0; after word NCOEF-1 the index wraps naturally.
      if (state == ST_IDLE) begin
        coef_idx <= '0;
      end else if (c_acc) begin
        fir_cin   <= cfg_cdata;
        fir_caddr <= coef_idx;
        coef_idx  <= coef_idx + CADDR_W'(1);
      end

      if (res_drop) ovf_err <= 1'b1;
    end
  end

  // Result capture
  assign m_valid  = ~res_empty;
  assign res_pop  = m_valid & m_ready;
  assign res_drop = fir_valid & res_full & ~res_pop;

  fir_result_fifo #(
    .WIDTH(FP16_W),
    .DEPTH(OUT_DEPTH)
  ) u_result_fifo (
    .clk       (clk2),
    .rst_n     (rst_n),
    .push      (fir_valid),
    .push_data (fir_dout),
    .pop       (res_pop),
    .full      (res_full),
    .empty     (res_empty),
    .head      (m_data)
  );
endmodule

// File: doc/fir_feeder.md
Name: fir_feeder

Overview:
- Host-side driver for the W4823 FIR block. Loads the 64 FIR coefficients through the FIR's cin/caddr/cload port.
- Streams FP16 samples into the FIR's din/valid_in port. It issues at most one sample per FIR frame, because the FIR frame is 258 fast cycles of load/mul/acc/norm/sleep.
- Captures each dout/valid result into a small output FIFO that presents a valid/ready stream.
- Runs entirely on the FIR fast clock.

Parameters:
- FRAME_CYCLES, 258: fast cycles between successive sample issues (1+63+6+64+1+123).
- NCOEF, 64: coefficients per load; caddr width 6.
- OUT_DEPTH, 4: result FIFO depth, power of 2, at least 2.

Ports:
- clk2 input 1: fast clock; the only clock.
- rst_n input 1: synchronous, active-low reset.
- cfg_start input 1: level request to begin a coefficient load.
- cfg_cdata input 17: coefficient word.
- cfg_cvalid input 1: coefficient word valid.
- cfg_cready output 1: coefficient word accepted when cfg_cvalid is also high.
- cfg_busy output 1: high while in the CLOAD state.
- s_data input 16: FP16 sample.
- s_valid input 1: sample valid.
- s_ready output 1: sample accepted when s_valid is also high.
- fir_din output 16: to FIR din.
- fir_valid_in output 1: to FIR valid_in.
- fir_cin output 17: to FIR cin.
- fir_caddr output 6: to FIR caddr.
- fir_cload output 1: to FIR cload.
- fir_dout input 16: from FIR dout.
- fir_valid input 1: from FIR valid.
- m_data output 16: result FIFO head.
- m_valid output 1: result FIFO not empty.
- m_ready input 1: downstream consumes the head.
- ovf_err output 1: sticky flag, a result was dropped.

Behaviour:
- Interface: one clock (clk2); rst_n is synchronous and active-low. All state updates occur on the clk2 rising edge.
- Reset (rst_n=0 at an edge) sets:
  - state to IDLE and slot_cnt to 0;
  - cfg_cready, cfg_busy, s_ready, fir_valid_in, fir_cload, m_valid and ovf_err to 0;
  - fir_din, fir_cin, fir_caddr and m_data to 0;
  - FIFO to empty.
- Reset mid-load abandons the partial coefficient set; no further cload pulses follow. Reset mid-frame forgets the in-flight sample.
- States:
  - IDLE: accepts samples.
  - CLOAD: accepts coefficients.
- slot_cnt: counter of 0..FRAME_CYCLES-1. While nonzero it decrements each cycle; while zero it holds.
- Sample issue:
  - s_ready = (state==IDLE) & (slot_cnt==0) & ~cfg_start. This is combinational from registers plus cfg_start.
  - On accept: next cycle fir_din=s_data and fir_valid_in=1 for exactly one cycle; slot_cnt loads FRAME_CYCLES-1.
  - The next accept is therefore possible exactly FRAME_CYCLES cycles after the previous one.
  - fir_din holds its value until the next issue.
- Coefficient load:
  - IDLE to CLOAD when cfg_start=1 and slot_cnt==0. cfg_start has priority over a simultaneous s_valid, whose sample stalls.
  - While slot_cnt!=0, cfg_start waits (level request, not latched).
  - In CLOAD: cfg_busy=1 and cfg_cready=1; coef_idx starts at 0.
  - Each accepted word: next cycle fir_cin=cfg_cdata, fir_caddr=coef_idx and fir_cload=1 for one cycle; coef_idx increments.
  - Gaps in cfg_cvalid produce cycles with fir_cload=0.
  - After word NCOEF-1 is accepted, the state returns to IDLE on the next cycle. cfg_cready drops that same cycle, so no 65th word is accepted. coef_idx wraps to 0.
  - cfg_start is ignored while in CLOAD.
- Result capture:
  - push = fir_valid; pop = m_valid & m_ready.
  - When not full, push writes fir_dout.
  - When full, push is accepted only if pop is asserted in the same cycle.
  - When full with no pop, the result is dropped and ovf_err is set to 1, sticky until reset.
  - Push and pop on the same cycle with the FIFO empty: the push is stored and pop has no effect, since m_valid was 0.
  - Latency: m_valid rises the cycle after a push into an empty FIFO.
  - m_data is registered from the FIFO head; first-in first-out order.
- fir_valid arriving during CLOAD is still captured.

Decomposition:
- Shared package fir_pkg holds:
  - FRAME_CYCLES=258 and NCOEF=64;
  - width constants FP16_W=16 and COEF_W=17;
  - state encoding ST_IDLE/ST_CLOAD.
- One sub-module: fir_result_fifo (synchronous FIFO with parameters WIDTH and DEPTH; ports push/pop/full/empty/head).

Test Plan:
1. Reset then coefficient load: hold cfg_start=1 and stream 64 words 0x00000..0x0003F with cfg_cvalid always 1. Require 64 fir_cload pulses with fir_caddr=0..63 and fir_cin=caddr, cfg_busy high for 64 cycles, and no 65th accept.
2. Sample pacing: s_valid held high with samples 0x3C00, 0x4000, 0x4200. Require fir_valid_in pulses exactly 258 cycles apart carrying those values, and s_ready low between them.
3. Priority: cfg_start and s_valid both rise with slot_cnt==0. Require entry to CLOAD with no fir_valid_in. Then raise cfg_start while slot_cnt=100; require CLOAD to begin only when slot_cnt reaches 0.
4. FIFO overflow: 5 fir_valid pulses (0x1111..0x5555) with m_ready=0. Require 4 stored, ovf_err=1, and drain order 0x1111..0x4444.
5. Full with simultaneous push/pop: FIFO full, fir_valid=1 with 0xABCD and m_ready=1. Require no drop, ovf_err stays 0, and 0xABCD exits last.
6. Reset at coefficient 30 of 64: require all outputs 0 the next cycle, no further fir_cload, and a subsequent load starting again at fir_caddr=0.
